// File: rtl/hex_seq_monitor_if.sv
// Bundle of the sampled HEX0 segment bus and the monitor's status outputs.
// The master drives the display samples; the monitor is the slave.
interface hex_seq_monitor_if #(parameter int CW = 8);
  logic [6:0]    seg_in;
  logic          seg_valid;
  logic          dir;
  logic [3:0]    digit;
  logic          locked;
  logic          seq_err;
  logic          bad_pat;
  logic [CW-1:0] cycle_count;
  logic [CW-1:0] err_count;

  modport master (
    output seg_in, seg_valid, dir,
    input  digit, locked, seq_err, bad_pat, cycle_count, err_count
  );

  modport slave (
    input  seg_in, seg_valid, dir,
    output digit, locked, seq_err, bad_pat, cycle_count, err_count
  );
endinterface

// File: rtl/hex_seq_monitor.sv
// On-chip self-check of the digit sequencer: decodes the active-low HEX0
// pattern and tracks it around the 2-4-0-3-1 ring in either direction.
module hex_seq_monitor #(
  parameter int CW = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  hex_seq_monitor_if.slave mon
);

  typedef enum logic {HUNT, TRACK} state_t;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t        state, state_nxt;
  logic [2:0]    pos, pos_nxt;
  logic [3:0]    digit_q, digit_nxt;
  logic          seq_err_q, seq_err_nxt;
  logic          bad_pat_q, bad_pat_nxt;
  logic [CW-1:0] cyc_q, cyc_nxt;
  logic [CW-1:0] err_q, err_nxt;

  logic [3:0]    dec;
  logic          ring_hit;
  logic [2:0]    ring_pos;
  logic [2:0]    succ;
  logic [CW-1:0] cyc_inc;
  logic [CW-1:0] err_inc;

  always_comb begin
    dec = 4'hF;
    case (mon.seg_in)
      7'b1000000: dec = 4'd0;
      7'b1111001: dec = 4'd1;
      7'b0100100: dec = 4'd2;
      7'b0110000: dec = 4'd3;
      7'b0011001: dec = 4'd4;
      7'b0010010: dec = 4'd5;
      7'b0000010: dec = 4'd6;
      7'b1111000: dec = 4'd7;
      7'b0000000: dec = 4'd8;
      7'b0010000: dec = 4'd9;
      default:    dec = 4'hF;
    endcase
  end

  // Ring position of the decoded digit, in forward order 2,4,0,3,1.
  always_comb begin
    ring_hit = 1'b1;
    ring_pos = 3'd0;
    case (dec)
      4'd2:    ring_pos = 3'd0;
      4'd4:    ring_pos = 3'd1;
      4'd0:    ring_pos = 3'd2;
      4'd3:    ring_pos = 3'd3;
      4'd1:    ring_pos = 3'd4;
      default: ring_hit = 1'b0;
    endcase
  end

  always_comb begin
    if (mon.dir) succ = (pos == 3'd4) ? 3'd0 : pos + 3'd1;
    else         succ = (pos == 3'd0) ? 3'd4 : pos - 3'd1;
  end

  assign cyc_inc = (cyc_q == CNT_MAX) ? cyc_q : cyc_q + CNT_ONE;
  assign err_inc = (err_q == CNT_MAX) ? err_q : err_q + CNT_ONE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= HUNT;
      pos       <= 3'd0;
      digit_q   <= 4'hF;
      seq_err_q <= 1'b0;
      bad_pat_q <= 1'b0;
      cyc_q     <= '0;
      err_q     <= '0;
    end else begin
      state     <= state_nxt;
      pos       <= pos_nxt;
      digit_q   <= digit_nxt;
      seq_err_q <= seq_err_nxt;
      bad_pat_q <= bad_pat_nxt;
      cyc_q     <= cyc_nxt;
      err_q     <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pos_nxt     = pos;
    digit_nxt   = digit_q;
    seq_err_nxt = 1'b0;
    bad_pat_nxt = 1'b0;
    cyc_nxt     = cyc_q;
    err_nxt     = err_q;

    if (mon.seg_valid) begin
      digit_nxt = dec;
      case (state)
        HUNT: begin
          if (ring_hit) begin
            pos_nxt   = ring_pos;
            state_nxt = TRACK;
          end else if (dec == 4'hF) begin
            bad_pat_nxt = 1'b1;
          end
        end
        TRACK: begin
          if (dec == 4'hF) begin
            bad_pat_nxt = 1'b1;
            state_nxt   = HUNT;
          end else if (!ring_hit) begin
            seq_err_nxt = 1'b1;
            err_nxt     = err_inc;
            state_nxt   = HUNT;
          end else if (ring_pos == succ) begin
            pos_nxt = succ;
            if (succ == 3'd0) cyc_nxt = cyc_inc;
          end else begin
            // Wrong ring digit (including a repeat): flag it and re-lock there.
            seq_err_nxt = 1'b1;
            err_nxt     = err_inc;
            pos_nxt     = ring_pos;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  assign mon.digit       = digit_q;
  assign mon.locked      = (state == TRACK);
  assign mon.seq_err     = seq_err_q;
  assign mon.bad_pat     = bad_pat_q;
  assign mon.cycle_count = cyc_q;
  assign mon.err_count   = err_q;

endmodule

// File: tb/tb_hex_seq_monitor.sv
// Bench for hex_seq_monitor: fixed vector table, multi-cycle corner sequences
// and random strobes against a digit-level reference model (CW=8 and CW=2).
module tb_hex_seq_monitor;

  localparam logic [6:0] P0 = 7'b1000000;
  localparam logic [6:0] P1 = 7'b1111001;
  localparam logic [6:0] P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000;
  localparam logic [6:0] P4 = 7'b0011001;
  localparam logic [6:0] P7 = 7'b1111000;
  localparam logic [6:0] PX = 7'b1111111;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  hex_seq_monitor_if #(.CW(8)) bus8();
  hex_seq_monitor_if #(.CW(2)) bus2();

  hex_seq_monitor #(.CW(8)) dut8 (.clk(clk), .reset_n(reset_n), .mon(bus8.slave));
  hex_seq_monitor #(.CW(2)) dut2 (.clk(clk), .reset_n(reset_n), .mon(bus2.slave));

  int checks = 0;
  int errors = 0;

  logic [6:0] digit_pat [10];
  logic [6:0] ring_pat  [5];
  int         ring_dig  [5];

  // Reference model state, kept in plain digit/position terms.
  bit m_track;
  int m_pos, m_digit, m_cyc, m_err;
  bit m_seq, m_bad;

  typedef struct packed {
    logic [6:0] seg;
    logic       valid;
    logic       dir;
    logic [3:0] digit;
    logic       locked;
    logic       seq_err;
    logic       bad_pat;
    int         cyc;
    int         err;
  } vec_t;

  vec_t vq[$];

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic int modelDecode(logic [6:0] s);
    for (int i = 0; i < 10; i++) if (digit_pat[i] == s) return i;
    return 15;
  endfunction

  function automatic int ringIndex(int d);
    for (int i = 0; i < 5; i++) if (ring_dig[i] == d) return i;
    return -1;
  endfunction

  task automatic modelReset();
    m_track = 0; m_pos = 0; m_digit = 15; m_cyc = 0; m_err = 0; m_seq = 0; m_bad = 0;
  endtask

  task automatic modelStep(logic [6:0] seg, logic valid, logic dir);
    int d, r, nxt;
    m_seq = 0;
    m_bad = 0;
    if (!valid) return;
    d = modelDecode(seg);
    r = ringIndex(d);
    m_digit = d;
    if (!m_track) begin
      if (r >= 0) begin m_track = 1; m_pos = r; end
      else if (d == 15) m_bad = 1;
    end else if (d == 15) begin
      m_bad = 1; m_track = 0;
    end else if (r < 0) begin
      m_seq = 1; m_err++; m_track = 0;
    end else begin
      nxt = dir ? (m_pos + 1) % 5 : (m_pos + 4) % 5;
      if (r == nxt) begin
        m_pos = r;
        if (r == 0) m_cyc++;
      end else begin
        m_seq = 1; m_err++; m_pos = r;
      end
    end
  endtask

  task automatic checkOutput(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic applyStimulus(logic [6:0] seg, logic valid, logic dir);
    @(negedge clk);
    bus8.seg_in = seg; bus8.seg_valid = valid; bus8.dir = dir;
    bus2.seg_in = seg; bus2.seg_valid = valid; bus2.dir = dir;
    @(posedge clk);
    modelStep(seg, valid, dir);
    #1;
  endtask

  task automatic checkAgainst(string tag, int idx, logic [3:0] d, logic l, logic se, logic bp, int cyc, int err);
    checkOutput({tag, ".digit"},   idx, 32'(bus8.digit),   32'(d));
    checkOutput({tag, ".locked"},  idx, 32'(bus8.locked),  32'(l));
    checkOutput({tag, ".seq_err"}, idx, 32'(bus8.seq_err), 32'(se));
    checkOutput({tag, ".bad_pat"}, idx, 32'(bus8.bad_pat), 32'(bp));
    checkOutput({tag, ".cyc8"},    idx, 32'(bus8.cycle_count), 32'(sat(cyc, 255)));
    checkOutput({tag, ".err8"},    idx, 32'(bus8.err_count),   32'(sat(err, 255)));
    checkOutput({tag, ".cyc2"},    idx, 32'(bus2.cycle_count), 32'(sat(cyc, 3)));
    checkOutput({tag, ".err2"},    idx, 32'(bus2.err_count),   32'(sat(err, 3)));
    checkOutput({tag, ".locked2"}, idx, 32'(bus2.locked),  32'(l));
  endtask

  task automatic checkModel(string tag, int idx);
    checkAgainst(tag, idx, 4'(m_digit), m_track, m_seq, m_bad, m_cyc, m_err);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset_n = 1'b0;
    bus8.seg_valid = 1'b0; bus2.seg_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    modelReset();
  endtask

  initial begin
    int idx;
    logic [6:0] seg;
    int pick;

    digit_pat = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    ring_pat  = '{P2, P4, P0, P3, P1};
    ring_dig  = '{2, 4, 0, 3, 1};

    bus8.seg_in = '0; bus8.seg_valid = 1'b0; bus8.dir = 1'b1;
    bus2.seg_in = '0; bus2.seg_valid = 1'b0; bus2.dir = 1'b1;

    //               seg valid dir  dig L se bp cyc err
    vq.push_back('{P2, 1, 1, 4'd2, 1, 0, 0, 0, 0});
    vq.push_back('{P4, 1, 1, 4'd4, 1, 0, 0, 0, 0});
    vq.push_back('{P0, 1, 1, 4'd0, 1, 0, 0, 0, 0});
    vq.push_back('{P3, 1, 1, 4'd3, 1, 0, 0, 0, 0});
    vq.push_back('{P1, 1, 1, 4'd1, 1, 0, 0, 0, 0});
    vq.push_back('{P2, 1, 1, 4'd2, 1, 0, 0, 1, 0});
    vq.push_back('{P1, 1, 0, 4'd1, 1, 0, 0, 1, 0});
    vq.push_back('{P3, 1, 0, 4'd3, 1, 0, 0, 1, 0});
    vq.push_back('{P0, 1, 0, 4'd0, 1, 0, 0, 1, 0});
    vq.push_back('{P4, 1, 0, 4'd4, 1, 0, 0, 1, 0});
    vq.push_back('{P2, 1, 0, 4'd2, 1, 0, 0, 2, 0});
    vq.push_back('{P1, 1, 0, 4'd1, 1, 0, 0, 2, 0});
    vq.push_back('{P2, 1, 1, 4'd2, 1, 0, 0, 3, 0});
    vq.push_back('{P4, 1, 1, 4'd4, 1, 0, 0, 3, 0});
    vq.push_back('{P2, 1, 0, 4'd2, 1, 0, 0, 4, 0});
    vq.push_back('{P4, 1, 1, 4'd4, 1, 0, 0, 4, 0});
    vq.push_back('{P0, 1, 1, 4'd0, 1, 0, 0, 4, 0});
    vq.push_back('{P3, 1, 1, 4'd3, 1, 0, 0, 4, 0});
    vq.push_back('{P1, 1, 1, 4'd1, 1, 0, 0, 4, 0});
    vq.push_back('{P2, 1, 1, 4'd2, 1, 0, 0, 5, 0});
    vq.push_back('{P3, 1, 1, 4'd3, 1, 1, 0, 5, 1});
    vq.push_back('{P1, 1, 1, 4'd1, 1, 0, 0, 5, 1});
    vq.push_back('{P7, 0, 1, 4'd1, 1, 0, 0, 5, 1});
    vq.push_back('{PX, 1, 1, 4'hF, 0, 0, 1, 5, 1});
    vq.push_back('{PX, 1, 1, 4'hF, 0, 0, 1, 5, 1});
    vq.push_back('{P7, 1, 1, 4'd7, 0, 0, 0, 5, 1});
    vq.push_back('{P3, 1, 1, 4'd3, 1, 0, 0, 5, 1});
    vq.push_back('{P3, 1, 1, 4'd3, 1, 1, 0, 5, 2});
    vq.push_back('{P7, 1, 1, 4'd7, 0, 1, 0, 5, 3});
    vq.push_back('{P0, 1, 1, 4'd0, 1, 0, 0, 5, 3});

    doReset();
    checkAgainst("reset", 0, 4'hF, 0, 0, 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      applyStimulus(vq[i].seg, vq[i].valid, vq[i].dir);
      checkAgainst("vec", i, vq[i].digit, vq[i].locked, vq[i].seq_err, vq[i].bad_pat,
                   vq[i].cyc, vq[i].err);
    end

    // Three forward cycles, then an asynchronous reset between clock edges.
    doReset();
    applyStimulus(P2, 1, 1);
    for (int c = 0; c < 3; c++)
      for (int k = 1; k <= 5; k++) applyStimulus(ring_pat[k % 5], 1, 1);
    checkAgainst("pre_areset", 0, 4'd2, 1, 0, 0, 3, 0);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checkAgainst("areset", 0, 4'hF, 0, 0, 0, 0, 0);
    modelReset();
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(P4, 1, 1);
    checkAgainst("post_areset", 0, 4'd4, 1, 0, 0, 0, 0);

    // Five full cycles and five mismatches: the CW=2 counters must stick at 3.
    doReset();
    applyStimulus(P2, 1, 1);
    for (int c = 0; c < 5; c++)
      for (int k = 1; k <= 5; k++) applyStimulus(ring_pat[k % 5], 1, 1);
    for (int k = 0; k < 5; k++) applyStimulus(P2, 1, 1);
    checkAgainst("saturate", 0, 4'd2, 1, 1, 0, 5, 5);
    checkOutput("sat_cyc2", 0, 32'(bus2.cycle_count), 32'd3);
    checkOutput("sat_err2", 0, 32'(bus2.err_count), 32'd3);

    // Random strobes against the reference model.
    doReset();
    for (idx = 0; idx < 400; idx++) begin
      pick = $urandom_range(0, 99);
      if (pick < 65)      seg = ring_pat[$urandom_range(0, 4)];
      else if (pick < 80) seg = digit_pat[$urandom_range(5, 9)];
      else                seg = 7'($urandom);
      applyStimulus(seg, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0));
      checkModel("rand", idx);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
